// File: rtl/lap_stopwatch.sv
// BCD mm:ss stopwatch core with LAP_DEPTH lap registers and recall.
// Optional macro LAP_RING_EN: a full lap memory overwrites its oldest entry.
module lap_stopwatch #(
  parameter int MAX_MIN   = 59,
  parameter int LAP_DEPTH = 4,
  parameter int LW        = $clog2(LAP_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          start_pb,
  input  logic          lap_pb,
  input  logic          recall_pb,
  output logic [3:0]    dig0,
  output logic [3:0]    dig1,
  output logic [3:0]    dig2,
  output logic [3:0]    dig3,
  output logic          running,
  output logic          recall_on,
  output logic [LW-1:0] lap_cnt,
  output logic          lap_full,
  output logic          ovf
);

  localparam int PW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam logic [7:0] MAX_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

  typedef enum logic [2:0] {IDLE, RUN, LAP_HOLD, PAUSE, RECALL} state_t;

  state_t        state;
  logic [15:0]   live, live_inc, live_nx, disp;
  logic [15:0]   laps [LAP_DEPTH];
  logic [PW-1:0] idx, wr_ptr, wr_ptr_inc, oldest, rd_next;
  logic          wrap, counting;

  function automatic logic [PW-1:0] slot_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (PW+1)'(LAP_DEPTH)) s = s - (PW+1)'(LAP_DEPTH);
    return s[PW-1:0];
  endfunction

  // BCD increment of {min_t, min_u, sec_t, sec_u}; wraps to 00:00 after MAX_MIN:59
  always_comb begin
    live_inc = live;
    wrap     = 1'b0;
    if (live[3:0] != 4'd9) begin
      live_inc[3:0] = live[3:0] + 4'd1;
    end else begin
      live_inc[3:0] = 4'd0;
      if (live[7:4] != 4'd5) begin
        live_inc[7:4] = live[7:4] + 4'd1;
      end else begin
        live_inc[7:4] = 4'd0;
        if (live[15:8] == MAX_BCD) begin
          live_inc = '0;
          wrap     = 1'b1;
        end else if (live[11:8] != 4'd9) begin
          live_inc[11:8] = live[11:8] + 4'd1;
        end else begin
          live_inc[11:8]  = 4'd0;
          live_inc[15:12] = live[15:12] + 4'd1;
        end
      end
    end
  end

  assign counting   = tick && (state == RUN || state == LAP_HOLD);
  assign live_nx    = counting ? live_inc : live;
  assign wr_ptr_inc = (wr_ptr == PW'(LAP_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
  assign rd_next    = slot_add(oldest, idx + PW'(1));

  // Once the ring has wrapped, the next write position holds the oldest lap
`ifdef LAP_RING_EN
  assign oldest = lap_full ? wr_ptr : '0;
`else
  assign oldest = '0;
`endif

  assign {dig3, dig2, dig1, dig0} = disp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      live      <= '0;
      disp      <= '0;
      idx       <= '0;
      wr_ptr    <= '0;
      lap_cnt   <= '0;
      lap_full  <= 1'b0;
      ovf       <= 1'b0;
      running   <= 1'b0;
      recall_on <= 1'b0;
      for (int i = 0; i < LAP_DEPTH; i++) laps[i] <= '0;
    end else begin
      live <= live_nx;
      if (counting && wrap) ovf <= 1'b1;
      case (state)
        IDLE: begin
          if (start_pb) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          disp <= live_nx;
          if (start_pb) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (lap_pb) begin
            // Capture the pre-tick value; a coincident tick only reaches live
            state <= LAP_HOLD;
            disp  <= live;
            if (!lap_full) begin
              laps[wr_ptr] <= live;
              wr_ptr       <= wr_ptr_inc;
              lap_cnt      <= lap_cnt + LW'(1);
              lap_full     <= (lap_cnt + LW'(1)) == LW'(LAP_DEPTH);
            end
`ifdef LAP_RING_EN
            else begin
              laps[wr_ptr] <= live;
              wr_ptr       <= wr_ptr_inc;
            end
`endif
          end
        end
        LAP_HOLD: begin
          if (start_pb) begin
            state   <= PAUSE;
            running <= 1'b0;
            disp    <= live_nx;
          end else if (lap_pb) begin
            state <= RUN;
            disp  <= live_nx;
          end
        end
        PAUSE: begin
          if (start_pb) begin
            state   <= RUN;
            running <= 1'b1;
          end else if (lap_pb) begin
            state    <= IDLE;
            live     <= '0;
            disp     <= '0;
            ovf      <= 1'b0;
            lap_cnt  <= '0;
            lap_full <= 1'b0;
            wr_ptr   <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) laps[i] <= '0;
          end else if (recall_pb && lap_cnt != '0) begin
            state     <= RECALL;
            recall_on <= 1'b1;
            idx       <= '0;
            disp      <= laps[oldest];
          end
        end
        RECALL: begin
          if (start_pb) begin
            state     <= RUN;
            running   <= 1'b1;
            recall_on <= 1'b0;
            disp      <= live;
          end else if (lap_pb || (recall_pb && (LW'(idx) + LW'(1)) == lap_cnt)) begin
            state     <= PAUSE;
            recall_on <= 1'b0;
            disp      <= live;
          end else if (recall_pb) begin
            idx  <= idx + PW'(1);
            disp <= laps[rd_next];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed self-checking bench for lap_stopwatch: default build (59 min, 4 laps)
// and a small build (1 min, 2 laps) driven by the same inputs.
module tb_lap_stopwatch;

  logic clk = 1'b0, rst = 1'b0, tick = 1'b0;
  logic start_pb = 1'b0, lap_pb = 1'b0, recall_pb = 1'b0;

  logic [3:0] a_dig0, a_dig1, a_dig2, a_dig3, b_dig0, b_dig1, b_dig2, b_dig3;
  logic       a_running, a_recall_on, a_lap_full, a_ovf;
  logic       b_running, b_recall_on, b_lap_full, b_ovf;
  logic [2:0] a_lap_cnt;
  logic [1:0] b_lap_cnt;

  wire [15:0] a_disp = {a_dig3, a_dig2, a_dig1, a_dig0};
  wire [15:0] b_disp = {b_dig3, b_dig2, b_dig1, b_dig0};

  int checkCount = 0;
  int errCount   = 0;

`ifdef LAP_RING_EN
  localparam logic [15:0] RECALL0 = 16'h0005, RECALL1 = 16'h0007;
`else
  localparam logic [15:0] RECALL0 = 16'h0003, RECALL1 = 16'h0005;
`endif

  lap_stopwatch dut_a (
    .clk(clk), .rst(rst), .tick(tick), .start_pb(start_pb), .lap_pb(lap_pb),
    .recall_pb(recall_pb), .dig0(a_dig0), .dig1(a_dig1), .dig2(a_dig2), .dig3(a_dig3),
    .running(a_running), .recall_on(a_recall_on), .lap_cnt(a_lap_cnt),
    .lap_full(a_lap_full), .ovf(a_ovf)
  );

  lap_stopwatch #(.MAX_MIN(1), .LAP_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .start_pb(start_pb), .lap_pb(lap_pb),
    .recall_pb(recall_pb), .dig0(b_dig0), .dig1(b_dig1), .dig2(b_dig2), .dig3(b_dig3),
    .running(b_running), .recall_on(b_recall_on), .lap_cnt(b_lap_cnt),
    .lap_full(b_lap_full), .ovf(b_ovf)
  );

  always #5 clk = ~clk;

  // One cycle of pulses {start, lap, recall, tick, rst}; outputs settle 1 time unit after the edge
  task automatic applyStimulus(input logic s, input logic l, input logic r, input logic t, input logic rs);
    start_pb  = s;
    lap_pb    = l;
    recall_pb = r;
    tick      = t;
    rst       = rs;
    @(posedge clk);
    #1;
    start_pb  = 1'b0;
    lap_pb    = 1'b0;
    recall_pb = 1'b0;
    tick      = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic applyTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset and count
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("rst_disp", 32'(a_disp), 32'h0000);
    checkOutput("rst_running", 32'(a_running), 32'd0);
    checkOutput("rst_recall_on", 32'(a_recall_on), 32'd0);
    checkOutput("rst_lap_cnt", 32'(a_lap_cnt), 32'd0);
    checkOutput("rst_lap_full", 32'(a_lap_full), 32'd0);
    checkOutput("rst_ovf", 32'(a_ovf), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("start_running", 32'(a_running), 32'd1);
    checkOutput("start_tick_ignored", 32'(a_disp), 32'h0000);
    applyTicks(75);
    checkOutput("count_0115", 32'(a_disp), 32'h0115);
    checkOutput("count_running", 32'(a_running), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rerst_disp", 32'(a_disp), 32'h0000);
    checkOutput("rerst_running", 32'(a_running), 32'd0);

    // Lap hold with a coincident tick
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyTicks(10);
    checkOutput("run_0010", 32'(a_disp), 32'h0010);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("hold_disp", 32'(a_disp), 32'h0010);
    checkOutput("hold_lap_cnt", 32'(a_lap_cnt), 32'd1);
    checkOutput("hold_running", 32'(a_running), 32'd1);
    applyTicks(5);
    checkOutput("hold_frozen", 32'(a_disp), 32'h0010);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_release_live", 32'(a_disp), 32'h0016);

    // Pause then clear
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pause_running", 32'(a_running), 32'd0);
    checkOutput("pause_disp", 32'(a_disp), 32'h0016);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("clear_disp", 32'(a_disp), 32'h0000);
    checkOutput("clear_lap_cnt", 32'(a_lap_cnt), 32'd0);

    // Priority: start beats lap in RUN; recall ignored with no laps
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyTicks(3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("prio_running", 32'(a_running), 32'd0);
    checkOutput("prio_no_lap", 32'(a_lap_cnt), 32'd0);
    checkOutput("prio_disp", 32'(a_disp), 32'h0003);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("recall_empty_off", 32'(a_recall_on), 32'd0);
    checkOutput("recall_empty_disp", 32'(a_disp), 32'h0003);

    // Recall exit via start resumes the paused count
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyTicks(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("recall_on", 32'(a_recall_on), 32'd1);
    checkOutput("recall_slot0", 32'(a_disp), 32'h0004);
    applyTicks(2);
    checkOutput("recall_no_count", 32'(a_disp), 32'h0004);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("resume_running", 32'(a_running), 32'd1);
    checkOutput("resume_recall_off", 32'(a_recall_on), 32'd0);
    applyTicks(1);
    checkOutput("resume_count", 32'(a_disp), 32'h0005);

    // Wrap on the MAX_MIN=1 instance
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyTicks(119);
    checkOutput("b_pre_wrap", 32'(b_disp), 32'h0159);
    checkOutput("b_pre_wrap_ovf", 32'(b_ovf), 32'd0);
    applyTicks(1);
    checkOutput("b_wrap_disp", 32'(b_disp), 32'h0000);
    checkOutput("b_wrap_ovf", 32'(b_ovf), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("b_clear_ovf", 32'(b_ovf), 32'd0);

    // Full memory on the LAP_DEPTH=2 instance
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyTicks(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyTicks(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("b_full_flag", 32'(b_lap_full), 32'd1);
    checkOutput("b_full_cnt", 32'(b_lap_cnt), 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyTicks(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("b_third_hold", 32'(b_disp), 32'h0007);
    checkOutput("b_third_cnt", 32'(b_lap_cnt), 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("b_recall_on", 32'(b_recall_on), 32'd1);
    checkOutput("b_recall_idx0", 32'(b_disp), 32'(RECALL0));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("b_recall_idx1", 32'(b_disp), 32'(RECALL1));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("b_recall_exit", 32'(b_recall_on), 32'd0);
    checkOutput("b_recall_exit_disp", 32'(b_disp), 32'h0007);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
    $finish;
  end

endmodule

// File: doc/lap_stopwatch.md
# lap_stopwatch

Parametrised stopwatch core with lap memory. It counts BCD mm:ss on an external tick pulse and is controlled by three debounced one-cycle button pulses: start/pause, lap/clear and recall. It stores up to LAP_DEPTH lap times and drives four BCD digits to the existing scan/decoder chain. The front-end clock divider and button debouncers stay outside this block.

## Interface
- MAX_MIN, 59: highest minute value (legal 1..99); the count wraps after MAX_MIN:59.
- LAP_DEPTH, 4: number of lap registers (legal 1..16).
- LW, $clog2(LAP_DEPTH+1): width of lap_cnt (derived).
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle count-enable pulse, one per second.
- start_pb  in  1  debounced one-cycle pulse: start/pause.
- lap_pb  in  1  debounced one-cycle pulse: lap capture, or clear when paused.
- recall_pb  in  1  debounced one-cycle pulse: step through stored laps.
- dig0  out  4  seconds units (BCD).
- dig1  out  4  seconds tens (BCD).
- dig2  out  4  minutes units (BCD).
- dig3  out  4  minutes tens (BCD).
- running  out  1  high in RUN and LAP_HOLD.
- recall_on  out  1  high in RECALL.
- lap_cnt  out  LW  number of stored laps.
- lap_full  out  1  lap_cnt == LAP_DEPTH.
- ovf  out  1  sticky flag: the count wrapped past MAX_MIN:59.

## Operation
- **States:** IDLE, RUN, LAP_HOLD, PAUSE, RECALL.
- **Live counter:**
  - Increments only on tick while in RUN or LAP_HOLD, judged on the state at that cycle.
  - Seconds run 00..59 and carry into minutes.
  - At MAX_MIN:59, a tick wraps the count to 00:00 and sets ovf.
- **Pulse priority:** start_pb > lap_pb > recall_pb. At most one pulse is acted on per cycle; the lower-priority pulses that cycle are dropped.
- **IDLE:**
  - start -> RUN.
  - lap and recall are ignored.
- **RUN:**
  - start -> PAUSE.
  - lap captures the current pre-tick value into lap slot lap_cnt, increments lap_cnt, and goes to LAP_HOLD.
  - If lap_full, nothing is stored, but LAP_HOLD is still entered.
- **LAP_HOLD:**
  - The display is frozen at the captured value while the live counter keeps running.
  - lap -> RUN, and the display returns to live.
  - start -> PAUSE, and the display shows the live count.
- **PAUSE:**
  - start -> RUN.
  - lap -> IDLE, clearing the counter, all lap slots, lap_cnt and ovf.
  - recall with lap_cnt > 0 -> RECALL at idx 0. With lap_cnt == 0, recall is ignored.
- **RECALL:**
  - The display shows lap slot idx.
  - recall increments idx; after idx lap_cnt-1, the block returns to PAUSE.
  - lap -> PAUSE.
  - start -> RUN. The live count resumes from its paused value.
- **Display source:**
  - Live counter in RUN, PAUSE and IDLE.
  - Hold register in LAP_HOLD.
  - lap slot idx in RECALL.
- **Reset:** the state returns to IDLE and every output is 0 (digits 0, running 0, recall_on 0, lap_cnt 0, lap_full 0, ovf 0). Reset mid-RUN or mid-RECALL behaves identically.

## Timing
- All outputs are registered.
- The digits reflect a tick on the cycle after the tick.
- State changes and their flags (running, recall_on) take effect on the cycle after the accepted pulse.
- A lap capture stores the value present in the cycle of the pulse. A tick in that same cycle is counted in the live counter only, not in the stored value.
- start_pb accepted from IDLE in the same cycle as a tick: that tick is not counted.
- lap_cnt and lap_full update on the cycle after the capture.
- Clear from PAUSE: all outputs read 0 on the next cycle.
- No combinational path exists from any input to any output.

## Configuration
- LAP_RING_EN defined:
  - When full, a capture overwrites the oldest slot (circular write pointer), and lap_cnt stays LAP_DEPTH.
  - RECALL idx 0 shows the oldest surviving lap.
- LAP_RING_EN undefined: captures are discarded when full, as described under Operation.

## Test plan
- **Reset and count:** rst 1 cycle, start_pb, then 75 ticks -> digits 01:15 and running=1. Then rst -> all outputs 0 on the next cycle.
- **Wrap:** MAX_MIN=1, RUN, 120 ticks -> digits 00:00 and ovf=1. Then PAUSE followed by lap -> ovf=0.
- **Lap hold:** RUN to 00:10, lap_pb coincident with a tick -> display holds 00:10, lap_cnt=1. After 5 more ticks and lap_pb -> display shows live 00:16.
- **Full memory:** LAP_DEPTH=2, three captures at 00:03, 00:05, 00:07. Without LAP_RING_EN, recall shows 00:03 then 00:05 and lap_full=1. With LAP_RING_EN, recall shows 00:05 then 00:07.
- **Priority:** start_pb and lap_pb asserted in the same cycle while in RUN -> PAUSE, with no lap stored. recall_pb in PAUSE with lap_cnt=0 -> stays in PAUSE.
- **Recall exit:** in RECALL, start_pb -> running=1, and the count continues from its paused value on the next tick.
